// File: rtl/cdb_arbiter.sv
// cdb_arbiter: two result FIFOs (int ALU, mem pipe) merged round-robin onto one CDB.
// Define CDB_STATS_EN to add saturating grant/conflict counters; otherwise they read 0.
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              int_valid,
  input  logic [TAG_W-1:0]  int_id,
  input  logic [DATA_W-1:0] int_value,
  output logic              int_ready,
  input  logic              mem_valid,
  input  logic [TAG_W-1:0]  mem_id,
  input  logic [DATA_W-1:0] mem_value,
  output logic              mem_ready,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_id,
  output logic [DATA_W-1:0] cdb_value,
  output logic              cdb_src,
  output logic [15:0]       int_grants,
  output logic [15:0]       mem_grants,
  output logic [15:0]       conflicts
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = TAG_W + DATA_W;

  logic [EW-1:0] buf_q [2][DEPTH];
  logic [PW-1:0] wr_q  [2];
  logic [PW-1:0] rd_q  [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [EW-1:0] din   [2];
  logic          rr_q, rr_d;
  logic [1:0]    ne, full, push, pop;
  logic [EW-1:0] head;

  always_comb begin
    din[0] = {int_id, int_value};
    din[1] = {mem_id, mem_value};
    for (int s = 0; s < 2; s++) begin
      ne[s]   = (cnt_q[s] != '0);
      full[s] = (cnt_q[s] == CW'(DEPTH));
    end
    // rr_q = 0 favours int, 1 favours mem
    pop[0]  = ne[0] && (!ne[1] || !rr_q);
    pop[1]  = ne[1] && (!ne[0] || rr_q);
    push[0] = int_valid && !full[0] && !flush;
    push[1] = mem_valid && !full[1] && !flush;
  end

  always_comb begin
    rr_d = rr_q;
    if (flush)       rr_d = 1'b0;
    else if (pop[0]) rr_d = 1'b1;
    else if (pop[1]) rr_d = 1'b0;
    for (int s = 0; s < 2; s++) begin
      cnt_d[s] = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
      if (flush) cnt_d[s] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        wr_q[s]  <= '0;
        rd_q[s]  <= '0;
        cnt_q[s] <= '0;
        for (int e = 0; e < DEPTH; e++) buf_q[s][e] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int s = 0; s < 2; s++) begin
        cnt_q[s] <= cnt_d[s];
        if (flush) begin
          wr_q[s] <= '0;
          rd_q[s] <= '0;
        end else begin
          if (push[s]) begin
            buf_q[s][wr_q[s]] <= din[s];
            wr_q[s] <= wr_q[s] + PW'(1);
          end
          if (pop[s]) rd_q[s] <= rd_q[s] + PW'(1);
        end
      end
    end
  end

  assign head      = buf_q[pop[1]][rd_q[pop[1]]];
  assign cdb_valid = |ne;
  assign cdb_src   = pop[1];
  assign cdb_id    = cdb_valid ? head[EW-1:DATA_W] : '0;
  assign cdb_value = cdb_valid ? head[DATA_W-1:0] : '0;
  assign int_ready = !full[0];
  assign mem_ready = !full[1];

`ifdef CDB_STATS_EN
  logic [15:0] ig_q, mg_q, cf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ig_q <= '0;
      mg_q <= '0;
      cf_q <= '0;
    end else begin
      if (pop[0] && ig_q != 16'hFFFF) ig_q <= ig_q + 16'd1;
      if (pop[1] && mg_q != 16'hFFFF) mg_q <= mg_q + 16'd1;
      if (&ne && cf_q != 16'hFFFF)    cf_q <= cf_q + 16'd1;
    end
  end

  assign int_grants = ig_q;
  assign mem_grants = mg_q;
  assign conflicts  = cf_q;
`else
  assign int_grants = 16'd0;
  assign mem_grants = 16'd0;
  assign conflicts  = 16'd0;
`endif

endmodule
